// File: rtl/ram_hs.sv
// Single-port synchronous RAM with a req/busy/done handshake and a fixed access latency.
// One access is in flight at a time. Writes merge per byte lane, and out-of-range addresses wrap.
module ram_hs #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data,
    input  logic [DATA_W/8-1:0] be,
    output logic                busy,
    output logic                done,
    output logic                range_err,
    output logic [DATA_W-1:0]   out
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {StIdle, StWait} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic [BE_W-1:0]    be_q;
    logic               done_q, rerr_q;
    logic [DATA_W-1:0]  out_q;
    logic               accept, complete;
    logic [IDX_W-1:0]   idx;

    logic [DATA_W-1:0]  mem [DEPTH];

    assign idx = addr_q[IDX_W-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            rerr_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= complete;
            // Widened compare so DEPTH == 2**ADDR_W cannot truncate to zero
            rerr_q  <= complete && ({1'b0, addr_q} >= (ADDR_W + 1)'(DEPTH));
            if (complete && !mode_q) begin
                out_q <= mem[idx];
            end
        end
    end

    // Operands are only meaningful while in StWait, so they carry no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            mode_q <= mode;
            addr_q <= address;
            data_q <= data;
            be_q   <= be;
        end
    end

    // Reset on the completion edge aborts the write
    always_ff @(posedge clk) begin
        if (rst_n && complete && mode_q) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (be_q[i]) begin
                    mem[idx][8*i +: 8] <= data_q[8*i +: 8];
                end
            end
        end
    end

    assign busy      = (state_q == StWait);
    assign done      = done_q;
    assign range_err = rerr_q;
    assign out       = out_q;

endmodule

// File: tb/tb_ram_hs.sv
// Randomized self-checking bench for ram_hs against a word-array reference model.
module tb_ram_hs;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 4096;
    localparam int LATENCY = 2;

    logic              clk;
    logic              rst_n;
    logic              req;
    logic              mode;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic [3:0]        be;
    logic              busy, done, range_err;
    logic [DATA_W-1:0] out;

    ram_hs #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mode      (mode),
        .address   (address),
        .data      (data),
        .be        (be),
        .busy      (busy),
        .done      (done),
        .range_err (range_err),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] mdl [DEPTH];
    logic [31:0] mdl_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or one later if poke)
    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input bit poke);
        int          cyc = 0;
        int          busy_cnt = 0;
        bit          early = 1'b0;
        logic [31:0] mask;
        int          widx;
        req = 1'b1; mode = wr; address = a; data = d; be = b;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (cyc == 0 && poke) begin
                req = 1'b1; mode = 1'b1; address = a; data = ~d; be = 4'hF;
            end else begin
                req = 1'b0;
            end
            if (done) break;
            busy_cnt += int'(busy);
            early |= range_err;
            cyc++;
            if (cyc > 10 * LATENCY + 10) begin
                check("done_timeout", 32'd0, 32'd1);
                req = 1'b0;
                return;
            end
        end
        check("latency", cyc, LATENCY);
        check("busy_cycles", busy_cnt, LATENCY);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("range_err_early", {31'd0, early}, 32'd0);
        check("range_err", {31'd0, range_err}, {31'd0, a >= DEPTH});
        widx = int'(a % DEPTH);
        if (wr) begin
            for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{b[i]}};
            mdl[widx] = (mdl[widx] & ~mask) | (d & mask);
        end else begin
            mdl_out = mdl[widx];
        end
        check(wr ? "out_after_write" : "read_data", out, mdl_out);
        if (poke) begin
            @(negedge clk);
            check("single_done", {31'd0, done}, 32'd0);
            check("idle_after_poke", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        // Reset with a write request already held high
        rst_n = 1'b0; req = 1'b1; mode = 1'b1; address = 32'd5;
        data = 32'hDEADBEEF; be = 4'hF;
        mdl_out = '0;
        repeat (2) begin
            @(negedge clk);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
            check("rst_rerr", {31'd0, range_err}, 32'd0);
            check("rst_out", out, 32'd0);
        end
        rst_n = 1'b1;
        access(1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 1'b0);
        access(1'b0, 32'd5, 32'h0, 4'h0, 1'b0);
        check("read5", out, 32'hDEADBEEF);

        // Byte merge
        @(negedge clk);
        access(1'b1, 32'd7, 32'h11223344, 4'hF, 1'b0);
        access(1'b1, 32'd7, 32'hAABBCCDD, 4'h5, 1'b0);
        access(1'b0, 32'd7, 32'h0, 4'hF, 1'b0);
        check("merge7", out, 32'h11BB33DD);

        // Wrap
        access(1'b1, DEPTH + 3, 32'h12345678, 4'hF, 1'b0);
        access(1'b0, 32'd3, 32'h0, 4'h0, 1'b0);
        check("wrap3", out, 32'h12345678);

        // Request while busy is ignored
        access(1'b1, 32'd9, 32'h55AA55AA, 4'hF, 1'b0);
        access(1'b0, 32'd9, 32'h0, 4'h0, 1'b1);
        access(1'b0, 32'd9, 32'h0, 4'h0, 1'b0);
        check("addr9_kept", out, 32'h55AA55AA);

        // Reset mid-write
        access(1'b1, 32'd2, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        req = 1'b1; mode = 1'b1; address = 32'd2; data = 32'hCAFEF00D; be = 4'hF;
        @(negedge clk);
        req = 1'b0; rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("abort_done", {31'd0, done}, 32'd0);
            check("abort_busy", {31'd0, busy}, 32'd0);
        end
        rst_n = 1'b1;
        mdl_out = '0;
        check("abort_out", out, 32'd0);
        access(1'b0, 32'd2, 32'h0, 4'h0, 1'b0);

        // Randomized traffic over a small set of indices, aliased through high address bits
        for (int i = 0; i < 16; i++) access(1'b1, i, $urandom, 4'hF, 1'b0);
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) a = a + DEPTH * $urandom_range(1, 1000);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_hs.md
Name: ram_hs

Overview:
- Parametrised single-port synchronous RAM with an explicit request/busy/done handshake and a programmable access latency.
- Generalises the fixed-width 32-bit RAM in data width, depth and latency.
- Adds per-byte write enables, an out-of-range address flag and synchronous reset of control state.
- Sits between the cache controller and backing storage; one access in flight at a time.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 32, width of the address input.
- DEPTH, 4096, number of words; must be a power of two and no greater than 2^ADDR_W.
- LATENCY, 2, cycles from request acceptance to completion; must be at least 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  1  request valid.
- mode  in  1  1 = write, 0 = read.
- address  in  ADDR_W  word address.
- data  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables for writes; bit i covers data[8i+7:8i]. Ignored on reads.
- busy  out  1  access in flight; new requests are not accepted.
- done  out  1  one-cycle completion pulse.
- range_err  out  1  valid with done; the completed access used an address >= DEPTH.
- out  out  DATA_W  read data of the most recent completed read.

Behaviour:
- Reset: when rst_n=0 at a rising edge, busy=0, done=0, range_err=0, out=0, state=IDLE and the latency counter is cleared. Memory contents are not cleared and are undefined until written.
- Reset mid-operation aborts the in-flight access. A pending write is never committed, and out keeps its value of 0.
- States:
  - IDLE: busy=0.
  - WAIT: busy=1.
- Acceptance: at an edge where state=IDLE and req=1, the block latches mode, address, data and be. It sets busy=1, loads the counter with LATENCY-1 and enters WAIT.
- req while busy=1 is ignored. It is not queued, and the latched operands do not change.
- WAIT behaviour:
  - The counter decrements each edge.
  - At the edge where the counter is 0 (edge E0+LATENCY, E0 = acceptance edge), the access is performed, busy goes to 0, done goes to 1 and state returns to IDLE.
- busy is high for exactly LATENCY cycles per access.
- done is high for exactly one cycle and cleared at the next edge.
- range_err equals (latched address >= DEPTH) during the done cycle and is 0 otherwise.
- Address mapping: word index = address mod DEPTH, i.e. the low log2(DEPTH) bits. Out-of-range addresses wrap and the access still occurs; only range_err reports it.
- Write: each byte lane with be[i]=1 is written with the latched data; lanes with be[i]=0 retain their contents.
  - A write does not change out.
  - be all zero produces a normal done pulse with no memory change.
- Read: out is loaded with the full word at the done edge and then held stable until the next read completes. Reads ignore be.
- Back-to-back requests: req may be high during the done cycle. It is accepted at the following edge, giving a minimum issue interval of LATENCY+1 cycles.
- Ordering: a read completing after a write to the same index returns the written data, with byte merging applied.
- Inputs other than req are don't-care while state=WAIT.

Test Plan:
1. Reset with req=1 held, rst_n=0 for 2 cycles -> busy=0, done=0, range_err=0, out=0 throughout. The first request is accepted on the first edge after rst_n=1.
2. LATENCY=2: write addr 5, data 0xDEADBEEF, be=0xF; then read addr 5 -> busy high for 2 cycles and done for 1 cycle per access, out=0xDEADBEEF after the read's done. out stays 0 after the write's done.
3. Byte merge: write 0x11223344 with be=0xF to addr 7, then write 0xAABBCCDD with be=0x5 to addr 7, then read addr 7 -> out=0x11BB33DD.
4. Wrap: write 0x12345678 to address 4096+3 (DEPTH=4096) -> range_err=1 with done. Reading addr 3 -> out=0x12345678 with range_err=0.
5. Request while busy: issue read addr 9, then pulse a write req one cycle after acceptance -> the write is ignored, only one done pulse occurs and addr 9 contents are unchanged.
6. Reset mid-write: accept write 0xCAFEF00D to addr 2 (addr 2 preloaded with 0x0), assert rst_n=0 before completion -> no done pulse. A subsequent read of addr 2 returns 0x0.
